// File: rtl/frame_stream_pkg.sv
// Shared definitions for marker-framed pixel streams: markers, FSM/mode encodings,
// colour-bar palette and LFSR taps.
package frame_stream_pkg;

  localparam int unsigned MaxWordWidth = 64;

  typedef enum logic [2:0] {
    StIdle,
    StFrameStart,
    StRowStart,
    StPixels,
    StFrameEnd
  } fs_state_e;

  typedef enum logic [1:0] {
    ModeCounter = 2'd0,
    ModeBars    = 2'd1,
    ModeLfsr    = 2'd2,
    ModeConst   = 2'd3
  } fs_mode_e;

  // Right-shifting Fibonacci LFSR, taps 16,14,13,11 seen from the output end.
  localparam logic [15:0] LfsrTapMask = 16'h002D;

  // Markers set the word MSB (bit pixel_width), which pixel words always clear.
  function automatic logic [MaxWordWidth-1:0] marker_frame_start(input int unsigned pixel_width);
    return MaxWordWidth'(1) << pixel_width;
  endfunction

  function automatic logic [MaxWordWidth-1:0] marker_row_start(input int unsigned pixel_width);
    return (MaxWordWidth'(1) << pixel_width) | MaxWordWidth'(1);
  endfunction

  function automatic logic [MaxWordWidth-1:0] marker_frame_end(input int unsigned pixel_width);
    return {MaxWordWidth{1'b1}} >> (MaxWordWidth - pixel_width - 1);
  endfunction

  function automatic logic [15:0] bar_colour(input logic [2:0] idx);
    logic [15:0] colour;
    unique case (idx)
      3'd0: colour = 16'hFFFF;
      3'd1: colour = 16'hFFE0;
      3'd2: colour = 16'h07FF;
      3'd3: colour = 16'h07E0;
      3'd4: colour = 16'hF81F;
      3'd5: colour = 16'hF800;
      3'd6: colour = 16'h001F;
      3'd7: colour = 16'h0000;
    endcase
    return colour;
  endfunction

endpackage

// File: rtl/frame_pattern_gen.sv
// Pixel pattern source: counter, LFSR and colour-bar column tracking, restarted per frame
// and stepped once per emitted pixel.
module frame_pattern_gen
  import frame_stream_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH = 480,
  parameter int unsigned PIXEL_WIDTH = 16,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   restart,
  input  logic                   advance,
  input  fs_mode_e               mode,
  input  logic [PIXEL_WIDTH-1:0] const_value,
  output logic [PIXEL_WIDTH-1:0] pixel
);

  localparam int unsigned BarWidth = (FRAME_WIDTH + 7) / 8;
  localparam int unsigned ColW     = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned BarPosW  = (BarWidth > 1) ? $clog2(BarWidth) : 1;
  localparam logic [ColW-1:0]    LastCol    = ColW'(FRAME_WIDTH - 1);
  localparam logic [BarPosW-1:0] LastBarPos = BarPosW'(BarWidth - 1);

  logic [PIXEL_WIDTH-1:0] count_q, count_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [BarPosW-1:0]     bar_pos_q, bar_pos_d;
  logic [2:0]             bar_idx_q, bar_idx_d;

  always_comb begin
    count_d   = count_q;
    lfsr_d    = lfsr_q;
    col_d     = col_q;
    bar_pos_d = bar_pos_q;
    bar_idx_d = bar_idx_q;
    if (restart) begin
      count_d   = '0;
      lfsr_d    = LFSR_SEED;
      col_d     = '0;
      bar_pos_d = '0;
      bar_idx_d = '0;
    end else if (advance) begin
      count_d = count_q + PIXEL_WIDTH'(1);
      lfsr_d  = {^(lfsr_q & LfsrTapMask), lfsr_q[15:1]};
      if (col_q == LastCol) begin
        col_d     = '0;
        bar_pos_d = '0;
        bar_idx_d = '0;
      end else begin
        col_d = col_q + ColW'(1);
        // Bar index tracked incrementally instead of dividing the column.
        if (bar_pos_q == LastBarPos) begin
          bar_pos_d = '0;
          if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
        end else begin
          bar_pos_d = bar_pos_q + BarPosW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      col_q     <= '0;
      bar_pos_q <= '0;
      bar_idx_q <= '0;
    end else begin
      count_q   <= count_d;
      lfsr_q    <= lfsr_d;
      col_q     <= col_d;
      bar_pos_q <= bar_pos_d;
      bar_idx_q <= bar_idx_d;
    end
  end

  always_comb begin
    unique case (mode)
      ModeCounter: pixel = count_q;
      ModeBars:    pixel = PIXEL_WIDTH'(bar_colour(bar_idx_q));
      ModeLfsr:    pixel = PIXEL_WIDTH'(lfsr_q);
      ModeConst:   pixel = const_value;
    endcase
  end

endmodule

// File: rtl/frame_stream_source.sv
// Marker-framed test-pattern source writing whole frames into a FIFO write port,
// with single-shot/continuous operation, graceful stop and a frame counter.
module frame_stream_source
  import frame_stream_pkg::*;
#(
  parameter int unsigned FRAME_WIDTH  = 480,
  parameter int unsigned FRAME_HEIGHT = 272,
  parameter int unsigned PIXEL_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   continuous,
  input  logic [1:0]             mode,
  input  logic [PIXEL_WIDTH-1:0] const_value,
  input  logic                   fifo_full,
  output logic [PIXEL_WIDTH:0]   fifo_data,
  output logic                   fifo_wr_en,
  output logic                   busy,
  output logic                   frame_done,
  output logic [COUNT_WIDTH-1:0] frame_count
);

  localparam int unsigned WordWidth = PIXEL_WIDTH + 1;
  localparam int unsigned ColW      = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;
  localparam int unsigned RowW      = (FRAME_HEIGHT > 1) ? $clog2(FRAME_HEIGHT) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(FRAME_WIDTH - 1);
  localparam logic [RowW-1:0] LastRow = RowW'(FRAME_HEIGHT - 1);
  localparam logic [WordWidth-1:0] FrameStartWord = WordWidth'(marker_frame_start(PIXEL_WIDTH));
  localparam logic [WordWidth-1:0] RowStartWord   = WordWidth'(marker_row_start(PIXEL_WIDTH));
  localparam logic [WordWidth-1:0] FrameEndWord   = WordWidth'(marker_frame_end(PIXEL_WIDTH));

  fs_state_e              state_q, state_d;
  logic                   word_valid_q, word_valid_d;
  logic [WordWidth-1:0]   data_q, data_d;
  logic [ColW-1:0]        col_q, col_d;
  logic [RowW-1:0]        row_q, row_d;
  fs_mode_e               mode_q, mode_d;
  logic [PIXEL_WIDTH-1:0] const_q, const_d;
  logic                   cont_q, cont_d;
  logic                   stop_pend_q, stop_pend_d;
  logic                   done_q, done_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  logic                   consume, last_col, last_row, frame_again, enter_frame;
  logic                   pat_restart, pat_advance;
  logic [PIXEL_WIDTH-1:0] pixel;

  assign consume     = word_valid_q & ~fifo_full;
  assign last_col    = (col_q == LastCol);
  assign last_row    = (row_q == LastRow);
  // A stop arriving on the same edge as FRAME_END still prevents the next frame.
  assign frame_again = cont_q & ~stop_pend_q & ~stop;
  assign enter_frame = ((state_q == StIdle) && start) ||
                       ((state_q == StFrameEnd) && consume && frame_again);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= StIdle;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:       if (start) state_d = StFrameStart;
      StFrameStart: if (consume) state_d = StRowStart;
      StRowStart:   if (consume) state_d = StPixels;
      StPixels:     if (consume && last_col) state_d = last_row ? StFrameEnd : StRowStart;
      StFrameEnd:   if (consume) state_d = frame_again ? StFrameStart : StIdle;
      default:      state_d = StIdle;
    endcase
  end

  // The output register always holds the next word to offer; loading a pixel steps the pattern.
  always_comb begin
    word_valid_d = word_valid_q;
    data_d       = data_q;
    col_d        = col_q;
    row_d        = row_q;
    mode_d       = mode_q;
    const_d      = const_q;
    cont_d       = cont_q;
    done_d       = 1'b0;
    count_d      = count_q;
    pat_restart  = 1'b0;
    pat_advance  = 1'b0;

    if (enter_frame) begin
      word_valid_d = 1'b1;
      data_d       = FrameStartWord;
      mode_d       = fs_mode_e'(mode);
      const_d      = const_value;
      cont_d       = continuous;
      pat_restart  = 1'b1;
    end

    case (state_q)
      StFrameStart: begin
        if (consume) begin
          data_d = RowStartWord;
          row_d  = '0;
        end
      end
      StRowStart: begin
        if (consume) begin
          data_d      = {1'b0, pixel};
          col_d       = '0;
          pat_advance = 1'b1;
        end
      end
      StPixels: begin
        if (consume) begin
          if (!last_col) begin
            data_d      = {1'b0, pixel};
            col_d       = col_q + ColW'(1);
            pat_advance = 1'b1;
          end else if (last_row) begin
            data_d = FrameEndWord;
          end else begin
            data_d = RowStartWord;
            row_d  = row_q + RowW'(1);
          end
        end
      end
      StFrameEnd: begin
        if (consume) begin
          done_d  = 1'b1;
          count_d = count_q + COUNT_WIDTH'(1);
          if (!frame_again) word_valid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (state_d == StIdle)                     stop_pend_d = 1'b0;
    else if (stop)                             stop_pend_d = 1'b1;
    else                                       stop_pend_d = stop_pend_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_valid_q <= 1'b0;
      data_q       <= '0;
      col_q        <= '0;
      row_q        <= '0;
      mode_q       <= ModeCounter;
      const_q      <= '0;
      cont_q       <= 1'b0;
      stop_pend_q  <= 1'b0;
      done_q       <= 1'b0;
      count_q      <= '0;
    end else begin
      word_valid_q <= word_valid_d;
      data_q       <= data_d;
      col_q        <= col_d;
      row_q        <= row_d;
      mode_q       <= mode_d;
      const_q      <= const_d;
      cont_q       <= cont_d;
      stop_pend_q  <= stop_pend_d;
      done_q       <= done_d;
      count_q      <= count_d;
    end
  end

  frame_pattern_gen #(
    .FRAME_WIDTH (FRAME_WIDTH),
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .LFSR_SEED   (LFSR_SEED)
  ) u_pattern (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart     (pat_restart),
    .advance     (pat_advance),
    .mode        (mode_q),
    .const_value (const_q),
    .pixel       (pixel)
  );

  assign fifo_data   = data_q;
  assign fifo_wr_en  = consume;
  assign busy        = (state_q != StIdle);
  assign frame_done  = done_q;
  assign frame_count = count_q;

endmodule

// File: tb/tb_frame_stream_source.sv
// Bench for frame_stream_source: two instances (23x17 and 16x3) checked against a
// frame-level reference model under random FIFO back-pressure.
module tb_frame_stream_source;

  localparam logic [16:0] Fs = 17'h10000;
  localparam logic [16:0] Rs = 17'h10001;
  localparam logic [16:0] Fe = 17'h1FFFF;
  localparam logic [15:0] Seed = 16'hACE1;
  localparam int AW = 23, AH = 17, BW = 16, BH = 3;
  localparam int CycleLimit = 4000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0, stop = 1'b0, continuous = 1'b0, fifo_full = 1'b0, sel = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [15:0] const_value = 16'h0;

  logic        a_start, a_wr, a_busy, a_done, b_start, b_wr, b_busy, b_done;
  logic [16:0] a_data, b_data;
  logic [15:0] a_count, b_count;
  logic        m_wr, m_busy, m_done;
  logic [16:0] m_data;
  logic [15:0] m_count;

  int checks = 0, failures = 0;
  logic [16:0] got_q[$];
  logic [16:0] exp_q[$];
  int done_seen, cycles, wr_full_bad;
  logic [15:0] bars [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                            16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  always #5 clk = ~clk;

  assign a_start = start & ~sel;
  assign b_start = start & sel;
  assign m_data  = sel ? b_data : a_data;
  assign m_wr    = sel ? b_wr : a_wr;
  assign m_busy  = sel ? b_busy : a_busy;
  assign m_done  = sel ? b_done : a_done;
  assign m_count = sel ? b_count : a_count;

  frame_stream_source #(
    .FRAME_WIDTH(AW), .FRAME_HEIGHT(AH), .PIXEL_WIDTH(16), .LFSR_SEED(Seed), .COUNT_WIDTH(16)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .start(a_start), .stop(stop), .continuous(continuous),
    .mode(mode), .const_value(const_value), .fifo_full(fifo_full), .fifo_data(a_data),
    .fifo_wr_en(a_wr), .busy(a_busy), .frame_done(a_done), .frame_count(a_count)
  );

  frame_stream_source #(
    .FRAME_WIDTH(BW), .FRAME_HEIGHT(BH), .PIXEL_WIDTH(16), .LFSR_SEED(Seed), .COUNT_WIDTH(16)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .start(b_start), .stop(stop), .continuous(continuous),
    .mode(mode), .const_value(const_value), .fifo_full(fifo_full), .fifo_data(b_data),
    .fifo_wr_en(b_wr), .busy(b_busy), .frame_done(b_done), .frame_count(b_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    logic fb;
    fb = l[0] ^ l[2] ^ l[3] ^ l[5];
    return {fb, l[15:1]};
  endfunction

  // Reference: one whole frame as the ordered list of words the FIFO must receive.
  task automatic model_frame(input int w, input int h, input int md, input logic [15:0] cv);
    int k, bw, idx;
    logic [15:0] lfsr, px;
    k = 0;
    lfsr = Seed;
    bw = (w + 7) / 8;
    exp_q.push_back(Fs);
    for (int r = 0; r < h; r++) begin
      exp_q.push_back(Rs);
      for (int c = 0; c < w; c++) begin
        case (md)
          0: px = 16'(k % 65536);
          1: begin
            idx = c / bw;
            if (idx > 7) idx = 7;
            px = bars[idx];
          end
          2: px = lfsr;
          default: px = cv;
        endcase
        exp_q.push_back({1'b0, px});
        k++;
        lfsr = lfsr_next(lfsr);
      end
    end
    exp_q.push_back(Fe);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame(input logic which, input logic [1:0] md, input logic cont,
                             input logic [15:0] cv, input int stall, input logic with_stop);
    sel = which;
    mode = md;
    continuous = cont;
    const_value = cv;
    fifo_full = (stall > 0) && ($urandom_range(0, 99) < stall);
    start = 1'b1;
    stop = with_stop;
    tick();
    start = 1'b0;
    stop = 1'b0;
    chk("busy_after_start", m_busy, 1);
    chk("first_word_frame_start", m_data, Fs);
  endtask

  // Records every consumed word until n have been taken; optional one-shot injections.
  task automatic collect(input int n, input int stall, input int stop_at, input int mode_at,
                         input logic [1:0] mode_new, input int start_at);
    logic [16:0] prev_data;
    logic prev_hold, stop_sent, mode_sent, start_sent;
    got_q.delete();
    done_seen = 0;
    cycles = 0;
    wr_full_bad = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    stop_sent = 1'b0;
    mode_sent = 1'b0;
    start_sent = 1'b0;
    while (got_q.size() < n && cycles < CycleLimit) begin
      @(negedge clk);
      cycles++;
      if (prev_hold) chk("stall_data_hold", m_data, prev_data);
      if (fifo_full && m_wr) wr_full_bad++;
      prev_hold = fifo_full && m_busy;
      prev_data = m_data;
      if (m_done) done_seen++;
      if (m_wr) got_q.push_back(m_data);
      @(posedge clk);
      #1;
      stop = 1'b0;
      start = 1'b0;
      if (stop_at >= 0 && !stop_sent && got_q.size() >= stop_at) begin
        stop = 1'b1;
        stop_sent = 1'b1;
      end
      if (start_at >= 0 && !start_sent && got_q.size() >= start_at) begin
        start = 1'b1;
        start_sent = 1'b1;
      end
      if (mode_at >= 0 && !mode_sent && got_q.size() >= mode_at) begin
        mode = mode_new;
        mode_sent = 1'b1;
      end
      fifo_full = (stall > 0) && ($urandom_range(0, 99) < stall);
    end
    stop = 1'b0;
    start = 1'b0;
    fifo_full = 1'b0;
    chk("no_write_while_full", wr_full_bad, 0);
  endtask

  task automatic compare(input string tag);
    int idx;
    idx = -1;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        idx = i;
        break;
      end
    end
    if (idx < 0) idx = exp_q.size() - 1;
    chk({tag, "_word"}, got_q[idx], exp_q[idx]);
  endtask

  task automatic idle_check(input string tag);
    int w;
    w = 0;
    repeat (5) begin
      @(negedge clk);
      if (m_wr) w++;
    end
    chk(tag, w, 0);
    chk({tag, "_busy"}, m_busy, 0);
  endtask

  initial begin
    int exp_count_a, exp_count_b, md, stall;
    logic [15:0] cv;
    exp_count_a = 0;
    exp_count_b = 0;

    // Reset state
    #3;
    chk("reset_data", a_data, 0);
    chk("reset_wr_en", a_wr, 0);
    chk("reset_busy", a_busy, 0);
    chk("reset_done", a_done, 0);
    chk("reset_count", a_count, 0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Counter frame, no back-pressure: 410 words, one per cycle
    begin_frame(1'b0, 2'd0, 1'b0, 16'h0, 0, 1'b0);
    collect(410, 0, -1, -1, 2'd0, -1);
    exp_q.delete();
    model_frame(AW, AH, 0, 16'h0);
    compare("counter_frame");
    chk("counter_cycles", cycles, 410);
    exp_count_a++;
    chk("counter_done_pulse", done_seen + int'(m_done), 1);
    chk("counter_busy_fall", m_busy, 0);
    chk("counter_frame_count", m_count, exp_count_a);
    idle_check("counter_idle");

    // Same frame under 50% back-pressure
    begin_frame(1'b0, 2'd0, 1'b0, 16'h0, 50, 1'b0);
    collect(410, 50, -1, -1, 2'd0, -1);
    compare("stall_frame");
    exp_count_a++;
    chk("stall_frame_count", m_count, exp_count_a);

    // LFSR, continuous, stop pulsed in frame 2
    begin_frame(1'b0, 2'd2, 1'b1, 16'h0, 0, 1'b0);
    collect(820, 0, 600, -1, 2'd0, -1);
    exp_q.delete();
    model_frame(AW, AH, 2, 16'h0);
    model_frame(AW, AH, 2, 16'h0);
    compare("lfsr_two_frames");
    chk("lfsr_no_gap_cycles", cycles, 820);
    chk("lfsr_f1_seed_pixel", got_q[2], {1'b0, Seed});
    chk("lfsr_f2_seed_pixel", got_q[412], {1'b0, Seed});
    chk("lfsr_done_pulses", done_seen + int'(m_done), 2);
    exp_count_a += 2;
    chk("lfsr_frame_count", m_count, exp_count_a);
    idle_check("lfsr_stopped_idle");

    // Random modes and back-pressure
    repeat (2) begin
      md = $urandom_range(0, 3);
      cv = 16'($urandom);
      stall = $urandom_range(0, 60);
      begin_frame(1'b0, 2'(md), 1'b0, cv, stall, 1'b0);
      collect(410, stall, -1, -1, 2'd0, -1);
      exp_q.delete();
      model_frame(AW, AH, md, cv);
      compare("random_frame");
      exp_count_a++;
      chk("random_frame_count", m_count, exp_count_a);
    end

    // Colour bars on W=16, mode switched to constant mid-frame
    cv = 16'($urandom);
    begin_frame(1'b1, 2'd1, 1'b0, cv, 30, 1'b0);
    collect(2 + BH * (BW + 1), 30, -1, 10, 2'd3, -1);
    exp_q.delete();
    model_frame(BW, BH, 1, cv);
    compare("bars_frame");
    exp_count_b++;
    chk("bars_frame_count", m_count, exp_count_b);
    idle_check("bars_idle");

    // Next frame picks up constant mode; start+stop together with continuous runs once
    begin_frame(1'b1, 2'd3, 1'b1, cv, 0, 1'b1);
    collect(2 + BH * (BW + 1), 0, -1, -1, 2'd0, -1);
    exp_q.delete();
    model_frame(BW, BH, 3, cv);
    compare("const_frame");
    exp_count_b++;
    chk("const_frame_count", m_count, exp_count_b);
    idle_check("start_stop_single_shot");

    // Reset mid-row aborts asynchronously
    begin_frame(1'b0, 2'd0, 1'b0, 16'h0, 0, 1'b0);
    collect(40, 0, -1, -1, 2'd0, -1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_reset_data", a_data, 0);
    chk("async_reset_wr_en", a_wr, 0);
    chk("async_reset_busy", a_busy, 0);
    chk("async_reset_done", a_done, 0);
    chk("async_reset_count", a_count, 0);
    tick();
    reset_n = 1'b1;
    tick();
    exp_count_a = 0;

    // Clean frame after reset; a start while busy is ignored
    begin_frame(1'b0, 2'd0, 1'b0, 16'h0, 20, 1'b0);
    collect(410, 20, -1, -1, 2'd0, 100);
    exp_q.delete();
    model_frame(AW, AH, 0, 16'h0);
    compare("post_reset_frame");
    exp_count_a++;
    chk("post_reset_frame_count", m_count, exp_count_a);
    idle_check("post_reset_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
